// File: rtl/ula_pkg.sv
// ula_pkg: op encodings, FSM states and control width shared by the ULA files
package ula_pkg;
  localparam int ULA_CTRL_W = 4;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SLT = 4'b0101,
    OP_XOR = 4'b1000,
    OP_SLL = 4'b1001,
    OP_SRL = 4'b1010,
    OP_SRA = 4'b1011,
    OP_MUL = 4'b1100
  } ula_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} ula_state_t;
endpackage

// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if: valid/ready operand and result bundle of the multicycle ULA
interface ula_multiciclo_if #(parameter int WIDTH = 8);
  import ula_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      SrcA;
  logic [WIDTH-1:0]      SrcB;
  logic [ULA_CTRL_W-1:0] ULAControl;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      ULAResult;
  logic                  CarryOut;
  logic                  Flag_z;
  logic                  Flag_ovf;
  logic                  Flag_neg;
  modport master (
    output in_valid, SrcA, SrcB, ULAControl, out_ready,
    input  in_ready, out_valid, ULAResult, CarryOut, Flag_z, Flag_ovf, Flag_neg
  );
  modport slave (
    input  in_valid, SrcA, SrcB, ULAControl, out_ready,
    output in_ready, out_valid, ULAResult, CarryOut, Flag_z, Flag_ovf, Flag_neg
  );
endinterface

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: iterative shift-add unsigned multiplier, one partial product per clock
module ula_mul_seq #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int SHW = $clog2(WIDTH);
  logic               busy;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;
  // acc holds {partial high, remaining multiplier bits}; product is the next step's value
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mcand};
  assign product = {sum, acc[WIDTH-1:1]};
  assign done    = busy && cnt == SHW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc  <= product;
      cnt  <= cnt + SHW'(1);
      busy <= !done;
    end
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: handshaked ULA with registered result/flags and a multicycle multiply
module ula_multiciclo import ula_pkg::*; #(parameter int WIDTH = 8) (
  input logic             clk,
  input logic             rst_n,
  ula_multiciclo_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_DONE = DONE;
  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ula_multiciclo: WIDTH must be a power of 2 and at least 4");
  end
  logic [1:0]         state, nxt;
  logic [WIDTH-1:0]   a, b, r, fr, res;
  logic [SHW-1:0]     sh;
  logic               c, v, fc, cout, z, ovf, neg, is_mul, start, load, mul_done;
  logic [2*WIDTH-1:0] prod;
  assign a      = bus.SrcA;
  assign b      = bus.SrcB;
  assign sh     = b[SHW-1:0];
  assign is_mul = bus.ULAControl == OP_MUL;
  assign start  = state == S_IDLE && bus.in_valid && is_mul;
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (ula_op_t'(bus.ULAControl))
      OP_ADD: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {c, r} = {1'b0, a} - {1'b0, b};
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = WIDTH'(a < b);
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      default: ;
    endcase
  end
  ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .done(mul_done), .product(prod)
  );
  // in EXEC the multiplier owns the result; the live inputs are ignored there
  assign fr   = state == S_EXEC ? prod[WIDTH-1:0] : r;
  assign fc   = state == S_EXEC ? |prod[2*WIDTH-1:WIDTH] : c;
  assign load = (state == S_IDLE && bus.in_valid && !is_mul) || (state == S_EXEC && mul_done);
  assign nxt  = state == S_IDLE ? (bus.in_valid ? (is_mul ? S_EXEC : S_DONE) : S_IDLE) :
                state == S_EXEC ? (mul_done ? S_DONE : S_EXEC) :
                (bus.out_ready ? S_IDLE : S_DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      res   <= '0;
      cout  <= 1'b0;
      z     <= 1'b0;
      ovf   <= 1'b0;
      neg   <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        res  <= fr;
        cout <= fc;
        z    <= fr == '0 && !fc;
        ovf  <= state == S_IDLE && v;
        neg  <= fr[WIDTH-1];
      end
    end
  assign bus.in_ready  = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.ULAResult = res;
  assign bus.CarryOut  = cout;
  assign bus.Flag_z    = z;
  assign bus.Flag_ovf  = ovf;
  assign bus.Flag_neg  = neg;
endmodule
